// File: rtl/gpio_turnaround_ctrl_pkg.sv
// Shared definitions for the GPIO bus-turnaround controller: state encoding,
// pad direction constants, parameter defaults and small helpers.
package gpio_ctrl_pkg;

  // Parameter defaults for the controller and its interface.
  localparam int WIDTH_DEFAULT = 8;
  localparam int TURN_DEFAULT  = 2;
  localparam int SYNC_DEFAULT  = 2;

  // Pad cell DIR pin levels: 1 releases the pad, 0 drives it from A.
  localparam logic DIR_IN  = 1'b1;
  localparam logic DIR_OUT = 1'b0;

  // Controller states.
  //   ST_IN       pads released, idle
  //   ST_TURN_OUT pads released, dead time before driving
  //   ST_OUT      pads driven, idle
  //   ST_TURN_IN  pads released, dead time before sampling
  //   ST_SAMPLE   waiting for the input synchronizer to flush
  typedef enum logic [2:0] {
    ST_IN       = 3'd0,
    ST_TURN_OUT = 3'd1,
    ST_OUT      = 3'd2,
    ST_TURN_IN  = 3'd3,
    ST_SAMPLE   = 3'd4
  } state_t;

  // Width of the shared phase down-counter; large enough for either load.
  function automatic int cnt_width(input int turn, input int sync);
    return $clog2(turn + sync + 1);
  endfunction

  // Requests are only taken while the bank is settled in one direction.
  function automatic logic state_accepts(input state_t st);
    return (st == ST_IN) || (st == ST_OUT);
  endfunction

endpackage

// File: rtl/gpio_turnaround_ctrl_if.sv
// Fabric-side request/response bundle of the GPIO turnaround controller.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1; req_write/req_data are only looked at on that edge.
// The requester may hold req_valid high while req_ready is low. Completion is
// a single-cycle rsp_valid pulse with rsp_data valid in the same cycle; there
// is no response backpressure. busy is the inverse of req_ready.
interface gpio_turnaround_ctrl_if
  import gpio_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [WIDTH-1:0] req_data;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             busy;

  // Fabric-side logic issuing requests.
  modport master (
    output req_valid,
    output req_write,
    output req_data,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data,
    input  busy
  );

  // The turnaround controller.
  modport slave (
    input  req_valid,
    input  req_write,
    input  req_data,
    output req_ready,
    output rsp_valid,
    output rsp_data,
    output busy
  );

endinterface

// File: rtl/gpio_turnaround_ctrl_sync.sv
// Multi-stage flop chain bringing the asynchronous pad Y pins into the clk
// domain. It runs continuously; the controller decides when to trust it.
module gpio_sync #(
  parameter int WIDTH = 8,
  parameter int SYNC  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [SYNC-1:0][WIDTH-1:0] stage_q;

  // Shift the pad value one stage per clock; stage 0 is the first capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[SYNC-2:0], d};
    end
  end

  assign q = stage_q[SYNC-1];

endmodule

// File: rtl/gpio_turnaround_ctrl.sv
// Bus-turnaround controller for a bank of GPIO pads sharing one DIR line.
// Serializes fabric reads and writes, inserts dead cycles on every direction
// change so the bank never drives while the far side may still be driving,
// and returns synchronized pad data on reads.
module gpio_turnaround_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int TURN  = TURN_DEFAULT,
  parameter int SYNC  = SYNC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  gpio_turnaround_ctrl_if.slave  bus,
  output logic [WIDTH-1:0]       gpio_a,
  output logic [WIDTH-1:0]       gpio_dir,
  input  logic [WIDTH-1:0]       gpio_y,
  output state_t                 dbg_state
);

  // Reject configurations that would break the dead-time guarantee or leave
  // the synchronizer with a single flop.
  if (TURN < 1) begin : g_bad_turn
    $error("gpio_turnaround_ctrl: TURN must be >= 1");
  end
  if (SYNC < 2) begin : g_bad_sync
    $error("gpio_turnaround_ctrl: SYNC must be >= 2");
  end

  localparam int            CW        = cnt_width(TURN, SYNC);
  localparam logic [CW-1:0] TURN_LOAD = CW'(TURN - 1);
  localparam logic [CW-1:0] SYNC_LOAD = CW'(SYNC - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             dir_q;
  logic [WIDTH-1:0] gpio_a_q;
  logic             rsp_valid_q;
  logic             rsp_from_pad;
  logic [WIDTH-1:0] rsp_hold;
  logic [WIDTH-1:0] sync_q;
  logic             ready;
  logic             accept;

  gpio_sync #(
    .WIDTH (WIDTH),
    .SYNC  (SYNC)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (gpio_y),
    .q   (sync_q)
  );

  assign ready  = state_accepts(state);
  assign accept = bus.req_valid & ready;

  // Controller FSM: state, phase counter and all registered pad/response
  // outputs. Each timed phase loads the counter on entry (value N-1 so the
  // phase lasts N cycles) and leaves when the counter reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IN;
      cnt          <= '0;
      dir_q        <= DIR_IN;
      gpio_a_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_from_pad <= 1'b0;
      rsp_hold     <= '0;
    end else begin
      rsp_valid_q  <= 1'b0;
      rsp_from_pad <= 1'b0;
      // Freeze the read result after its completion cycle so rsp_data stays
      // stable instead of following the pads.
      if (rsp_from_pad) begin
        rsp_hold <= sync_q;
      end
      case (state)
        ST_IN: begin
          if (accept) begin
            if (bus.req_write) begin
              gpio_a_q <= bus.req_data;
              cnt      <= TURN_LOAD;
              state    <= ST_TURN_OUT;
            end else begin
              cnt   <= SYNC_LOAD;
              state <= ST_SAMPLE;
            end
          end
        end
        ST_TURN_OUT: begin
          if (cnt == '0) begin
            dir_q       <= DIR_OUT;
            rsp_valid_q <= 1'b1;
            rsp_hold    <= gpio_a_q;
            state       <= ST_OUT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_OUT: begin
          if (accept) begin
            if (bus.req_write) begin
              gpio_a_q    <= bus.req_data;
              rsp_valid_q <= 1'b1;
              rsp_hold    <= bus.req_data;
            end else begin
              dir_q <= DIR_IN;
              cnt   <= TURN_LOAD;
              state <= ST_TURN_IN;
            end
          end
        end
        ST_TURN_IN: begin
          if (cnt == '0) begin
            cnt   <= SYNC_LOAD;
            state <= ST_SAMPLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_SAMPLE: begin
          if (cnt == '0) begin
            rsp_valid_q  <= 1'b1;
            rsp_from_pad <= 1'b1;
            state        <= ST_IN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          dir_q <= DIR_IN;
          state <= ST_IN;
        end
      endcase
    end
  end

  // On a read completion the synchronizer output is passed straight through
  // so the returned value is the freshest fully synchronized pad sample.
  assign bus.rsp_data  = rsp_from_pad ? sync_q : rsp_hold;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.req_ready = ready;
  assign bus.busy      = ~ready;
  assign gpio_a        = gpio_a_q;
  assign gpio_dir      = {WIDTH{dir_q}};
  assign dbg_state     = state;

endmodule

// File: tb/tb_gpio_turnaround_ctrl.sv
// Self-checking bench for gpio_turnaround_ctrl with TURN=2, SYNC=2, WIDTH=8.
module tb_gpio_turnaround_ctrl;
  import gpio_ctrl_pkg::*;

  localparam int W    = 8;
  localparam int TURN = 2;
  localparam int SYNC = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  gpio_turnaround_ctrl_if #(.WIDTH(W)) bus ();
  logic [W-1:0] gpio_a;
  logic [W-1:0] gpio_dir;
  logic [W-1:0] y_ext;
  state_t       dbg_state;

  gpio_turnaround_ctrl #(
    .WIDTH (W),
    .TURN  (TURN),
    .SYNC  (SYNC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .gpio_a    (gpio_a),
    .gpio_dir  (gpio_dir),
    .gpio_y    (y_ext),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           total = 0;
  int           bad   = 0;
  logic         ext_drive = 1'b0;
  logic         model_out = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until accepted (bounded); on acceptance
  // optionally queue the expected response. Returns 1 ns after the
  // acceptance edge, i.e. in cycle 1.
  task automatic issue(input logic wr, input logic [W-1:0] d, input logic exp_rsp,
                       input logic [W-1:0] exp_d, input int lat);
    int n;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_data  = d;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout cyc=%0d actual=0 expected=1", cyc);
    end else if (exp_rsp) begin
      exp_q.push_back(exp_d);
      exp_cyc_q.push_back(cyc + lat);
    end
    step();
    bus.req_valid = 1'b0;
  endtask

  // Response monitor: every rsp_valid pulse must match the oldest expectation
  // in both data and arrival cycle.
  always @(negedge clk) begin
    if (bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp cyc=%0d actual=%0h expected=none", cyc, bus.rsp_data);
      end else begin
        logic [W-1:0] e;
        int           ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("rsp_data", 32'(bus.rsp_data), 32'(e));
        check("rsp_cycle", cyc, ec);
      end
    end
  end

  // Contention: the bank must be released whenever the external model drives.
  always @(negedge clk) begin
    if (ext_drive) check("contention", 32'(gpio_dir), 32'hFF);
  end

  // Dead time between a release (0->1) and the next drive (1->0) of DIR.
  logic dir_prev = 1'b1;
  logic rst_prev = 1'b1;
  int   rise_cyc = -1000;
  always @(negedge clk) begin
    if (rst || rst_prev) begin
      rise_cyc = -1000;
    end else begin
      if (!dir_prev && gpio_dir[0]) rise_cyc = cyc;
      if (dir_prev && !gpio_dir[0] && rise_cyc > -1000) begin
        total++;
        if (cyc - rise_cyc < TURN + SYNC + 1) begin
          bad++;
          $display("FAIL dead_time cyc=%0d actual=%0d expected>=%0d", cyc, cyc - rise_cyc,
                   TURN + SYNC + 1);
        end
      end
    end
    dir_prev = gpio_dir[0];
    rst_prev = rst;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_data  = '0;
    y_ext         = 8'hA5;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dir", 32'(gpio_dir), 32'hFF);
    check("rst_gpio_a", 32'(gpio_a), 32'h00);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'h00);
    check("rst_state", 32'(dbg_state), 32'(ST_IN));
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    step();

    // Read from IN, pads held at A5: response in cycle 3
    issue(1'b0, 8'h00, 1'b1, 8'hA5, 3);
    @(negedge clk);
    check("rd_in_dir_c1", 32'(gpio_dir), 32'hFF);
    check("rd_in_busy_c1", 32'(bus.busy), 32'd1);
    step();
    @(negedge clk);
    check("rd_in_dir_c2", 32'(gpio_dir), 32'hFF);
    check("rd_in_ready_c2", 32'(bus.req_ready), 32'd0);
    step();
    @(negedge clk);
    check("rd_in_dir_c3", 32'(gpio_dir), 32'hFF);
    check("rd_in_ready_c3", 32'(bus.req_ready), 32'd1);
    step();

    // Write 3C from IN: A at cycle 1, DIR drops and response at cycle 3
    issue(1'b1, 8'h3C, 1'b1, 8'h3C, 3);
    @(negedge clk);
    check("wr_in_a_c1", 32'(gpio_a), 32'h3C);
    check("wr_in_dir_c1", 32'(gpio_dir), 32'hFF);
    step();
    @(negedge clk);
    check("wr_in_dir_c2", 32'(gpio_dir), 32'hFF);
    step();
    @(negedge clk);
    check("wr_in_dir_c3", 32'(gpio_dir), 32'h00);
    check("wr_in_state_c3", 32'(dbg_state), 32'(ST_OUT));
    step();

    // Back-to-back writes while driving
    y_ext = 8'h00;
    issue(1'b1, 8'h01, 1'b1, 8'h01, 1);
    check("b2b_a_01", 32'(gpio_a), 32'h01);
    check("b2b_ready_01", 32'(bus.req_ready), 32'd1);
    issue(1'b1, 8'h02, 1'b1, 8'h02, 1);
    check("b2b_a_02", 32'(gpio_a), 32'h02);
    check("b2b_ready_02", 32'(bus.req_ready), 32'd1);
    issue(1'b1, 8'h03, 1'b1, 8'h03, 1);
    check("b2b_a_03", 32'(gpio_a), 32'h03);

    // Read from OUT; pads change to 5A at cycle 3, response in cycle 5
    issue(1'b0, 8'h99, 1'b1, 8'h5A, 5);
    ext_drive = 1'b1;
    @(negedge clk);
    check("rd_out_dir_c1", 32'(gpio_dir), 32'hFF);
    check("rd_out_a_hold", 32'(gpio_a), 32'h03);
    step();
    step();
    y_ext = 8'h5A;
    @(negedge clk);
    check("rd_out_state_c3", 32'(dbg_state), 32'(ST_SAMPLE));
    check("rd_out_busy_c3", 32'(bus.busy), 32'd1);
    step();
    step();
    ext_drive = 1'b0;

    // Write right after the read: DIR must stay released for TURN cycles
    issue(1'b1, 8'hC3, 1'b1, 8'hC3, 3);
    @(negedge clk);
    check("wr_after_rd_dir_c1", 32'(gpio_dir), 32'hFF);
    step();
    @(negedge clk);
    check("wr_after_rd_dir_c2", 32'(gpio_dir), 32'hFF);
    step();
    @(negedge clk);
    check("wr_after_rd_dir_c3", 32'(gpio_dir), 32'h00);
    step();
    step();

    // Reset while driving
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_dir", 32'(gpio_dir), 32'hFF);
    check("rst_out_a", 32'(gpio_a), 32'h00);
    check("rst_out_rsp", 32'(bus.rsp_valid), 32'd0);
    check("rst_out_state", 32'(dbg_state), 32'(ST_IN));
    step();

    // Reset during TURN_OUT: request dropped, pads stay released
    issue(1'b1, 8'h77, 1'b0, 8'h00, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_to_dir", 32'(gpio_dir), 32'hFF);
    check("rst_to_a", 32'(gpio_a), 32'h00);
    check("rst_to_state", 32'(dbg_state), 32'(ST_IN));
    step();
    @(negedge clk);
    check("rst_to_dir_c3", 32'(gpio_dir), 32'hFF);
    step();
    step();

    // req_valid held while busy with changing data: only accepted values count
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_data  = 8'hAA;
    @(negedge clk);
    check("hold_ready_c0", 32'(bus.req_ready), 32'd1);
    exp_q.push_back(8'hAA);
    exp_cyc_q.push_back(cyc + TURN + 1);
    step();
    for (int i = 0; i < 2; i++) begin
      bus.req_data  = 8'($urandom_range(0, 255));
      bus.req_write = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("hold_a_busy", 32'(gpio_a), 32'hAA);
      check("hold_ready_busy", 32'(bus.req_ready), 32'd0);
      step();
    end
    bus.req_data  = 8'h55;
    bus.req_write = 1'b1;
    @(negedge clk);
    check("hold_ready_c3", 32'(bus.req_ready), 32'd1);
    check("hold_a_c3", 32'(gpio_a), 32'hAA);
    exp_q.push_back(8'h55);
    exp_cyc_q.push_back(cyc + 1);
    step();
    bus.req_valid = 1'b0;
    check("hold_a_55", 32'(gpio_a), 32'h55);
    model_out = 1'b1;

    // Randomized mix: dead-time, contention and response checks run alongside
    for (int k = 0; k < 30; k++) begin
      logic         wr;
      logic [W-1:0] d;
      logic [W-1:0] yv;
      int           lat;
      wr = 1'($urandom_range(0, 1));
      d  = 8'($urandom_range(0, 255));
      yv = 8'($urandom_range(0, 255));
      if (wr) lat = model_out ? 1 : TURN + 1;
      else    lat = model_out ? TURN + SYNC + 1 : SYNC + 1;
      issue(wr, d, 1'b1, wr ? d : yv, lat);
      if (!wr) y_ext = yv;
      ext_drive = !wr;
      model_out = wr;
      repeat ($urandom_range(0, 2)) step();
    end

    // Drain outstanding responses (bounded)
    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
        step();
        n++;
      end
    end
    check("drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
